// File: rtl/weight_store_arbiter.sv
// Round-robin arbiter for the single read port of the weight store.
// A grant is a whole-transaction lock: once a client owns the store, its
// sel/addr pass straight through until it drops req or the watchdog fires.
module weight_store_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int SEL_W    = 6,
  parameter int ADDR_W   = 16,
  parameter int MAX_HOLD = 65535
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*SEL_W-1:0]  sel_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic [7:0]                rdata_o,
  output logic [NUM_REQ-1:0]        rvalid_o,
  output logic [SEL_W-1:0]          w_sel_o,
  output logic [ADDR_W-1:0]         w_addr_o,
  input  logic [7:0]                w_data_i,
  output logic                      timeout_o,
  output logic                      busy_o
);

  localparam int OWN_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t            state;
  logic [OWN_W-1:0]  owner;
  logic [OWN_W-1:0]  rr_ptr;
  logic [HOLD_W-1:0] hold_cnt;

  logic              pick_valid;
  logic [OWN_W-1:0]  pick_idx;
  logic              owner_req;
  logic [OWN_W-1:0]  owner_next;

  // Round-robin pick: lowest requester at or above rr_ptr, else the lowest
  // requester overall (the wrap-around part of the scan).
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    pick_valid = |req_i;
    pick_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_i[k]) pick_idx = OWN_W'(k);
    end
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_i[k] && (OWN_W'(k) >= rr_ptr)) pick_idx = OWN_W'(k);
    end
  end

  // Owner's fields to the store; selected whole per client so two clients'
  // fields can never mix, and forced to zero whenever nobody owns the store.
  always_comb begin
    owner_req = 1'b0;
    w_sel_o   = '0;
    w_addr_o  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner == OWN_W'(k)) begin
        owner_req = req_i[k];
        if (state == S_BUSY) begin
          w_sel_o  = sel_i[k*SEL_W +: SEL_W];
          w_addr_o = addr_i[k*ADDR_W +: ADDR_W];
        end
      end
    end
  end

  // Next round-robin start: the client just after the releasing owner.
  assign owner_next = (owner == OWN_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  // Store read data is broadcast; clients qualify it with rvalid_o.
  assign rdata_o = w_data_i;

  // Arbitration FSM with registered grant, busy, rvalid and watchdog flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      grant_o   <= '0;
      rvalid_o  <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      hold_cnt  <= '0;
      timeout_o <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      rvalid_o <= grant_o;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            grant_o  <= NUM_REQ'(1) << pick_idx;
            owner    <= pick_idx;
            hold_cnt <= '0;
            busy_o   <= 1'b1;
            state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (!owner_req || (hold_cnt == HOLD_W'(MAX_HOLD - 1))) begin
            grant_o <= '0;
            busy_o  <= 1'b0;
            rr_ptr  <= owner_next;
            state   <= S_IDLE;
            if (owner_req) timeout_o <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
